// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;

  typedef enum logic {REQ_ALU = 1'b0, REQ_MEM = 1'b1} req_e;
endpackage

// File: rtl/reg_addr_decoder.sv
// Register address to one-hot enable; the zero register never decodes.
module reg_addr_decoder
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [NUM_REGS-1:0]   onehot
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_dec
    if (i == ZERO_REG) begin : g_zero
      assign onehot[i] = 1'b0;
    end else begin : g_reg
      assign onehot[i] = en && (addr == ADDR_WIDTH'(i));
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-port (ALU / load) writeback arbiter with round-robin tie break,
// one registered write stage and a pending-write scoreboard.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic [NUM_REGS-1:0]   wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REGS-1:0]   busy
);

  req_e                  last_q;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic [NUM_REGS-1:0]   wr_dec;
  logic [NUM_REGS-1:0]   rsv_dec;

  // Readies are gated by reset_n so nothing is accepted while held in reset.
  always_comb begin
    alu_ready = reset_n && alu_valid && (!mem_valid || last_q == REQ_MEM);
    mem_ready = reset_n && mem_valid && (!alu_valid || last_q == REQ_ALU);
    xfer      = alu_ready || mem_ready;
    gnt_addr  = alu_ready ? alu_addr : mem_addr;
    gnt_data  = alu_ready ? alu_data : mem_data;
  end

  reg_addr_decoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_dec (
    .en     (xfer),
    .addr   (gnt_addr),
    .onehot (wr_dec)
  );

  reg_addr_decoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_rsv_dec (
    .en     (rsv_valid),
    .addr   (rsv_addr),
    .onehot (rsv_dec)
  );

  // Reset leaves last_q at MEM so the ALU wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q  <= REQ_MEM;
      wr_en   <= '0;
      wr_data <= '0;
      busy    <= '0;
    end else begin
      wr_en <= wr_dec;
      if (xfer) begin
        wr_data <= gnt_data;
        last_q  <= alu_ready ? REQ_ALU : REQ_MEM;
      end
      // Clear on the capture edge, but a same-edge reservation wins.
      busy <= (busy & ~wr_en) | rsv_dec;
    end
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning write-data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning register-address width (32 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port alu_valid  input  1  ALU writeback request.
REQ-006 SHALL have port alu_addr  input  ADDR_WIDTH  ALU destination register.
REQ-007 SHALL have port alu_data  input  DATA_WIDTH  ALU result.
REQ-008 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-009 SHALL have port mem_valid  input  1  load writeback request.
REQ-010 SHALL have port mem_addr  input  ADDR_WIDTH  load destination register.
REQ-011 SHALL have port mem_data  input  DATA_WIDTH  load data.
REQ-012 SHALL have port mem_ready  output  1  load request accepted this cycle.
REQ-013 SHALL have port rsv_valid  input  1  issue stage reserves a destination.
REQ-014 SHALL have port rsv_addr  input  ADDR_WIDTH  register being reserved.
REQ-015 SHALL have port wr_en  output  32  one-hot write enable to register array.
REQ-016 SHALL have port wr_data  output  DATA_WIDTH  write data to register array.
REQ-017 SHALL have port busy  output  32  scoreboard: register has pending write.

Function
REQ-018 Handshake: transfer occurs on a rising edge where valid and ready are both 1; ready SHALL be combinational from valids and the priority pointer, and SHALL NOT depend on ready.
REQ-019 At most one of alu_ready/mem_ready SHALL be 1 per cycle; a lone valid requester SHALL be granted immediately.
REQ-020 Both valid: grant the requester not granted last; pointer updates only on a transfer.
REQ-021 Latency: request transferred at edge N SHALL drive wr_en/wr_data from N until N+1; array captures at edge N+1; otherwise wr_en SHALL be all zeros.
REQ-022 wr_en SHALL be the one-hot decode of the granted address; address 31 (zero register) SHALL be accepted but produce wr_en all zeros.
REQ-023 wr_data SHALL hold its last value when no write is issued.
REQ-024 busy[a] SHALL set at the edge where rsv_valid=1 with rsv_addr=a, for a != 31; busy[31] SHALL always be 0.
REQ-025 busy[a] SHALL clear at the edge where wr_en[a]=1 (same edge the array captures).
REQ-026 Simultaneous set and clear of the same register: set SHALL win (busy stays 1).
REQ-027 Both requesters valid with identical address: only the granted one writes; the other waits and writes on a later cycle, both in order of grant.
REQ-028 Valid deasserted before grant: request SHALL be dropped with no side effects.

Reset
REQ-029 reset_n=0 SHALL immediately force wr_en=0, wr_data=0, busy=0, pointer so ALU wins the first tie.
REQ-030 While reset_n=0, alu_ready and mem_ready SHALL be 0; in-flight write in output stage SHALL be discarded.
REQ-031 First grant possible on the first rising edge after reset_n deasserts.

Structure
REQ-032 Package regfile_pkg SHALL hold NUM_REGS=32, ZERO_REG=31 and requester enum {REQ_ALU, REQ_MEM}.
REQ-033 One sub-module, reg_addr_decoder (ADDR_WIDTH-to-one-hot), SHALL generate wr_en.
REQ-034 Outputs wr_en, wr_data, busy SHALL be registered; readies combinational.

Verification
REQ-035 Reset, then alu_valid=1 addr=3 data=0xAA for one cycle -> alu_ready=1; next cycle wr_en=0x0000_0008, wr_data=0xAA; following cycle wr_en=0.
REQ-036 Both valid continuously (alu addr 1, mem addr 2) for 4 cycles -> grants ALU,MEM,ALU,MEM; wr_en 0x2,0x4,0x2,0x4.
REQ-037 mem_valid=1 addr=31 data=0xFF -> mem_ready=1, wr_en stays 0, busy[31]=0.
REQ-038 rsv addr=5 -> busy[5]=1; ALU write addr 5 -> busy[5]=0 at edge wr_en[5]=1; repeat with rsv addr=5 at that same edge -> busy[5] stays 1.
REQ-039 Assert reset_n=0 mid-write (wr_en=0x8, busy=0x8) -> wr_en, busy, wr_data 0 immediately without clock; readies 0.
